keyboard_fifo_ctrl: RTL

- Sequences the PS/2 keyboard decoder output into a bus-readable key queue for the MIPS core.
- Watches the decoder's toggle-style stroke flag and captures the ASCII code and its parity/stop status.
- Validates each key and pushes it into a DEPTH-entry FIFO.
- Exposes DATA/STATUS/CONTROL registers on a simple 2-bit-address bus with 1-cycle read latency and a level interrupt.

---
 rtl/keyboard_fifo_ctrl_if.sv | 28 ++
 rtl/keyboard_fifo_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/keyboard_fifo_ctrl_if.sv
// Decoder-side and register-bus signals of the keyboard FIFO controller.
// The master drives the decoder and bus strobes, and the slave is the controller.
interface keyboard_fifo_ctrl_if;
  logic [7:0]  iKey_ascii_D;
  logic        iKey_parity_D;
  logic        iKey_stopbit_D;
  logic        iKey_stroke;
  logic [1:0]  iAddr;
  logic        iRead;
  logic        iWrite;
  logic [31:0] iWdata;
  logic [31:0] oRdata;
  logic        oRvalid;
  logic        oIrq;
  logic        oEmpty;

  modport master (
    output iKey_ascii_D, iKey_parity_D, iKey_stopbit_D, iKey_stroke,
    output iAddr, iRead, iWrite, iWdata,
    input  oRdata, oRvalid, oIrq, oEmpty
  );

  modport slave (
    input  iKey_ascii_D, iKey_parity_D, iKey_stopbit_D, iKey_stroke,
    input  iAddr, iRead, iWrite, iWdata,
    output oRdata, oRvalid, oIrq, oEmpty
  );
endinterface

// File: rtl/keyboard_fifo_ctrl.sv
// Captures toggle-flagged PS/2 keys, validates them into a DEPTH-entry FIFO
// and exposes DATA/STATUS/CONTROL registers with a level interrupt.
module keyboard_fifo_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 iClock,
  input  logic                 iReset_N,
  keyboard_fifo_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, CHECK} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic              stroke_q;
  logic [7:0]        hold_ascii;
  logic              hold_par, hold_stop;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf, err, unf;
  logic              chk_en, irq_en;
  logic [31:0]       rdata_q, rdata_nxt;
  logic              rvalid_q, irq_q;

  logic key_event, load_hold, key_chk, good;
  logic full, empty;
  logic rd_en, wr_en, ctrl_wr, flush;
  logic pop, push, push_req, ovf_set, err_set, unf_set, stat_clr;
  logic unused_wdata;

  assign unused_wdata = ^bus.iWdata[31:3];

  assign key_event = (bus.iKey_stroke != stroke_q);
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  // A simultaneous read wins over a write, so a write is only honoured alone.
  assign rd_en    = bus.iRead;
  assign wr_en    = bus.iWrite & ~bus.iRead;
  assign ctrl_wr  = wr_en & (bus.iAddr == 2'd2);
  assign flush    = ctrl_wr & bus.iWdata[1];
  assign pop      = rd_en & (bus.iAddr == 2'd0) & ~empty;
  assign unf_set  = rd_en & (bus.iAddr == 2'd0) & empty;
  assign stat_clr = rd_en & (bus.iAddr == 2'd1);

  always_comb begin
    state_nxt = state;
    load_hold = 1'b0;
    key_chk   = 1'b0;
    case (state)
      IDLE: begin
        if (key_event) begin
          load_hold = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        key_chk = 1'b1;
        if (key_event) load_hold = 1'b1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign good     = hold_stop & (hold_par | ~chk_en);
  assign push_req = key_chk & good;
  assign push     = push_req & ~flush & (~full | pop);
  assign ovf_set  = push_req & ~flush & full & ~pop;
  assign err_set  = key_chk & ~good;

  always_comb begin
    rdata_nxt = '0;
    case (bus.iAddr)
      2'd0: if (!empty) rdata_nxt[7:0] = mem[rd_ptr];
      2'd1: begin
        rdata_nxt[ADDR_W+8:8] = count;
        rdata_nxt[3]          = unf;
        rdata_nxt[2]          = err;
        rdata_nxt[1]          = ovf;
        rdata_nxt[0]          = empty;
      end
      2'd2: begin
        rdata_nxt[2] = chk_en;
        rdata_nxt[0] = irq_en;
      end
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset_N) begin
    if (!iReset_N) begin
      state      <= IDLE;
      stroke_q   <= 1'b0;
      hold_ascii <= '0;
      hold_par   <= 1'b0;
      hold_stop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      stroke_q <= bus.iKey_stroke;
      if (load_hold) begin
        hold_ascii <= bus.iKey_ascii_D;
        hold_par   <= bus.iKey_parity_D;
        hold_stop  <= bus.iKey_stopbit_D;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (push) mem[wr_ptr] <= hold_ascii;
  end

  always_ff @(posedge iClock or negedge iReset_N) begin
    if (!iReset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky bits: a set arriving with a STATUS read survives the clear.
  always_ff @(posedge iClock or negedge iReset_N) begin
    if (!iReset_N) begin
      ovf      <= 1'b0;
      err      <= 1'b0;
      unf      <= 1'b0;
      chk_en   <= 1'b0;
      irq_en   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ovf <= (ovf & ~stat_clr) | ovf_set;
      err <= (err & ~stat_clr) | err_set;
      unf <= (unf & ~stat_clr) | unf_set;
      if (ctrl_wr) begin
        irq_en <= bus.iWdata[0];
        chk_en <= bus.iWdata[2];
      end
      rdata_q  <= rd_en ? rdata_nxt : '0;
      rvalid_q <= rd_en;
      irq_q    <= irq_en & (~empty | ovf | err);
    end
  end

  assign bus.oRdata  = rdata_q;
  assign bus.oRvalid = rvalid_q;
  assign bus.oIrq    = irq_q;
  assign bus.oEmpty  = empty;

endmodule
